// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, read-return owner
// encoding and the fixed access size used for debug transfers.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} arb_state_t;
  typedef enum logic {OWN_CORE, OWN_DBG} mem_owner_t;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating count of consecutive cycles the debug master was refused.
// Clear wins over increment.
module arb_starve_counter #(
  parameter int CNT_W   = 4,
  parameter int MAX_VAL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_max
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_VAL);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count < LP_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_at_max = (r_count == LP_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Single data-memory port shared between the MEM stage and a debug master:
// core priority, bounded dbg starvation, and a halt handshake for dbg.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_core_rd,
  input  logic                  i_core_wr,
  input  logic [DM_ADDRESS-1:0] i_core_addr,
  input  logic [DATA_W-1:0]     i_core_wdata,
  input  logic [2:0]            i_core_funct3,
  output logic                  o_core_stall,
  output logic                  o_core_rvalid,
  output logic [DATA_W-1:0]     o_core_rdata,
  input  logic                  i_dbg_req,
  input  logic                  i_dbg_we,
  input  logic [DM_ADDRESS-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0]     i_dbg_wdata,
  output logic                  o_dbg_gnt,
  output logic                  o_dbg_rvalid,
  output logic [DATA_W-1:0]     o_dbg_rdata,
  input  logic                  i_dbg_halt_req,
  output logic                  o_halt_ack,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic [DM_ADDRESS-1:0] o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [2:0]            o_mem_funct3,
  input  logic [DATA_W-1:0]     i_mem_rdata
);

  arb_state_t r_state, w_state_next;
  logic       r_rd_pending;
  mem_owner_t r_rd_owner;

  logic w_core_req;
  logic w_gnt_core;
  logic w_gnt_dbg;
  logic w_at_max;
  logic w_core_rd_inflight;

  assign w_core_req         = i_core_rd | i_core_wr;
  assign w_core_rd_inflight = r_rd_pending && (r_rd_owner == OWN_CORE);

  arb_starve_counter #(
    .CNT_W  (CNT_W),
    .MAX_VAL(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (~i_dbg_req | w_gnt_dbg),
    .i_inc   (i_dbg_req & ~w_gnt_dbg),
    .o_at_max(w_at_max)
  );

  // Grants are forced low during reset so every output reads 0.
  always_comb begin
    w_gnt_core = 1'b0;
    w_gnt_dbg  = 1'b0;
    if (!reset) begin
      if (r_state == RUN) begin
        if (i_dbg_req && w_at_max) begin
          w_gnt_dbg = 1'b1;
        end else if (w_core_req) begin
          w_gnt_core = 1'b1;
        end else if (i_dbg_req) begin
          w_gnt_dbg = 1'b1;
        end
      end else begin
        w_gnt_dbg = i_dbg_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN: begin
        if (i_dbg_halt_req) w_state_next = HALT_PEND;
      end
      HALT_PEND: begin
        if (!i_dbg_halt_req) begin
          w_state_next = RUN;
        end else if (!w_core_rd_inflight) begin
          w_state_next = HALTED;
        end
      end
      HALTED: begin
        if (!i_dbg_halt_req) w_state_next = RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

  always_comb begin
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    o_mem_funct3 = '0;
    if (w_gnt_core) begin
      o_mem_read   = i_core_rd;
      o_mem_write  = i_core_wr;
      o_mem_addr   = i_core_addr;
      o_mem_wdata  = i_core_wdata;
      o_mem_funct3 = i_core_funct3;
    end else if (w_gnt_dbg) begin
      o_mem_read   = ~i_dbg_we;
      o_mem_write  = i_dbg_we;
      o_mem_addr   = i_dbg_addr;
      o_mem_wdata  = i_dbg_wdata;
      o_mem_funct3 = FUNCT3_WORD;
    end
  end

  assign o_core_stall = ~reset & w_core_req & ~w_gnt_core;
  assign o_dbg_gnt    = w_gnt_dbg;
  assign o_halt_ack   = ~reset & (r_state == HALTED);

  // Remember who issued the read so the one-cycle-later data is routed back.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_pending <= 1'b0;
      r_rd_owner   <= OWN_CORE;
    end else begin
      r_rd_pending <= o_mem_read;
      if (o_mem_read) begin
        r_rd_owner <= w_gnt_dbg ? OWN_DBG : OWN_CORE;
      end
    end
  end

  assign o_core_rvalid = ~reset & r_rd_pending & (r_rd_owner == OWN_CORE);
  assign o_dbg_rvalid  = ~reset & r_rd_pending & (r_rd_owner == OWN_DBG);
  assign o_core_rdata  = o_core_rvalid ? i_mem_rdata : '0;
  assign o_dbg_rdata   = o_dbg_rvalid ? i_mem_rdata : '0;

endmodule
